alu_microseq: RTL and testbench

Multi-cycle micro-sequencer that drives the register bank / 32-bit ALU datapath from a small loadable program of micro-ops. Each micro-op is a 16-bit word {func[3:0], rd[3:0], rs1[3:0], rs2[3:0]}. The sequencer steps through the program with a start/busy/done handshake, presenting register addresses and the ALU function code for two cycles per op. It asserts the bank write enable only in the second cycle. It replaces fixed opcode-to-control decoding so arbitrary instruction sequences can run on the shared datapath.

---
 rtl/alu_microseq_if.sv | 30 +++
 rtl/alu_microseq.sv | 122 ++++++++++++
 tb/tb_alu_microseq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_microseq_if.sv
// Bundle of program-load, control and datapath-control signals between the
// sequencer and whoever loads/starts it.
interface alu_microseq_if #(
  parameter int AW = 3
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic          start;
  logic [AW:0]   len;
  logic          abort;
  logic [3:0]    func;
  logic [3:0]    rd_addr;
  logic [3:0]    rs1_addr;
  logic [3:0]    rs2_addr;
  logic          reg_we;
  logic          busy;
  logic          done;
  logic [AW-1:0] pc;

  modport master (
    output prog_we, prog_addr, prog_data, start, len, abort,
    input  func, rd_addr, rs1_addr, rs2_addr, reg_we, busy, done, pc
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, len, abort,
    output func, rd_addr, rs1_addr, rs2_addr, reg_we, busy, done, pc
  );
endinterface

// File: rtl/alu_microseq.sv
// Micro-op sequencer: steps a loadable program of {func,rd,rs1,rs2} words,
// two cycles per op (ISSUE settles the datapath, WRITE strobes the bank).
module alu_microseq #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic          clk,
  input logic          rst,
  alu_microseq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WRITE, DONE} state_t;

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [3:0]  HALT    = 4'hF;

  logic [15:0]   store [DEPTH];

  state_t        state, state_n;
  logic [AW-1:0] pc_q, pc_n;
  logic [AW:0]   cnt, cnt_n;
  logic          abort_flag, abort_flag_n;
  logic [AW:0]   len_clamped;
  logic          cur_halt;
  logic [15:0]   op_n;
  logic          in_op_n;

  logic [3:0]    func_q, rd_q, rs1_q, rs2_q;
  logic          reg_we_q, busy_q, done_q;

  assign len_clamped = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
  assign cur_halt    = (store[pc_q][15:12] == HALT);

  // Program store has no reset; it only accepts writes while idle.
  always_ff @(posedge clk) begin
    if (bus.prog_we && state == IDLE) begin
      store[bus.prog_addr] <= bus.prog_data;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc_q;
    cnt_n        = cnt;
    abort_flag_n = abort_flag;
    case (state)
      IDLE: begin
        if (bus.start) begin
          abort_flag_n = 1'b0;
          cnt_n        = len_clamped;
          if (len_clamped == '0) begin
            state_n = DONE;
          end else begin
            state_n = ISSUE;
            pc_n    = '0;
          end
        end
      end
      ISSUE: begin
        state_n = WRITE;
        if (bus.abort) abort_flag_n = 1'b1;
      end
      WRITE: begin
        cnt_n = cnt - 1'b1;
        if (bus.abort) abort_flag_n = 1'b1;
        // An abort sampled this very cycle still lets the current op finish.
        if (abort_flag || bus.abort || cur_halt || cnt == CNT_ONE) begin
          state_n = DONE;
        end else begin
          state_n = ISSUE;
          pc_n    = pc_q + 1'b1;
        end
      end
      DONE: begin
        state_n      = IDLE;
        abort_flag_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  assign op_n    = store[pc_n];
  assign in_op_n = (state_n == ISSUE) || (state_n == WRITE);

  // Outputs are precomputed from the next state so they come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc_q       <= '0;
      cnt        <= '0;
      abort_flag <= 1'b0;
      func_q     <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      reg_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_n;
      pc_q       <= pc_n;
      cnt        <= cnt_n;
      abort_flag <= abort_flag_n;
      func_q     <= in_op_n ? op_n[15:12] : 4'h0;
      rd_q       <= in_op_n ? op_n[11:8]  : 4'h0;
      rs1_q      <= in_op_n ? op_n[7:4]   : 4'h0;
      rs2_q      <= in_op_n ? op_n[3:0]   : 4'h0;
      reg_we_q   <= (state_n == WRITE) && (op_n[15:12] != HALT);
      busy_q     <= in_op_n;
      done_q     <= (state_n == DONE);
    end
  end

  assign bus.func     = func_q;
  assign bus.rd_addr  = rd_q;
  assign bus.rs1_addr = rs1_q;
  assign bus.rs2_addr = rs2_q;
  assign bus.reg_we   = reg_we_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pc       = pc_q;
endmodule

// File: tb/tb_alu_microseq.sv
// Bench for alu_microseq: directed table, hand-written corner sequences and
// random programs compared cycle-by-cycle against an op-list reference model.
module tb_alu_microseq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_microseq_if #(.AW(3)) bus ();
  alu_microseq #(.DEPTH(8), .AW(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [3:0] func;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       we;
    logic       busy;
    logic       done;
    logic [2:0] pc;
  } out_t;

  typedef struct {
    logic [3:0] len;
    int         ab;
    int         writes;
    int         done_c;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [15:0] mprog [8];
  logic [2:0]  m_pc = 3'd0;
  out_t        exp_arr [64];
  logic [15:0] base [8];
  vec_t        tbl [7];

  function automatic out_t sample();
    out_t s;
    s = {bus.func, bus.rd_addr, bus.rs1_addr, bus.rs2_addr,
         bus.reg_we, bus.busy, bus.done, bus.pc};
    return s;
  endfunction

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, c, act, expv);
    end
  endtask

  // Reference: walk the op list, two cycles per op, stopping on count, HALT or abort.
  task automatic build_model(input logic [3:0] l, input int ab, output int last, output int done_c);
    int n;
    int c;
    bit stop;
    logic [15:0] op;
    n = (l > 8) ? 8 : int'(l);
    c = 1;
    stop = 0;
    for (int i = 0; i < n && !stop; i++) begin
      op = mprog[i];
      exp_arr[c] = {op[15:12], op[11:8], op[7:4], op[3:0], 1'b0, 1'b1, 1'b0, 3'(i)};
      c++;
      exp_arr[c] = {op[15:12], op[11:8], op[7:4], op[3:0], (op[15:12] != 4'hF), 1'b1, 1'b0, 3'(i)};
      m_pc = 3'(i);
      if (op[15:12] == 4'hF || (ab >= 1 && ab <= c)) stop = 1;
      c++;
    end
    exp_arr[c] = {16'h0, 1'b0, 1'b0, 1'b1, m_pc};
    done_c = c;
    c++;
    exp_arr[c] = {16'h0, 1'b0, 1'b0, 1'b0, m_pc};
    last = c;
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_data = d;
    @(posedge clk); #1;
    bus.prog_we = 1'b0;
    mprog[a] = d;
  endtask

  task automatic run_seq(input logic [3:0] l, input int ab, input int inj,
                         output int writes, output int done_c);
    int last;
    int mdone;
    build_model(l, ab, last, mdone);
    bus.len = l; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.len = '0;
    writes = 0;
    done_c = -1;
    for (int c = 1; c <= last; c++) begin
      chk("trace", c, 32'(sample()), 32'(exp_arr[c]));
      if (bus.reg_we) writes++;
      if (bus.done && done_c < 0) done_c = c;
      bus.abort = (c == ab);
      if (c == inj) begin
        bus.prog_we = 1'b1; bus.prog_addr = 3'd0; bus.prog_data = 16'h4112;
        bus.start = 1'b1; bus.len = 4'd2;
      end else begin
        bus.prog_we = 1'b0; bus.start = 1'b0; bus.len = '0;
      end
      @(posedge clk); #1;
    end
    bus.abort = 1'b0; bus.prog_we = 1'b0; bus.start = 1'b0; bus.len = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=0 got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int d;
    logic [3:0] rl;
    int rab;
    logic [15:0] word;

    base[0] = 16'h0123; base[1] = 16'h1415; base[2] = 16'hA212; base[3] = 16'h3456;
    base[4] = 16'h5678; base[5] = 16'h6789; base[6] = 16'h789A; base[7] = 16'h89AB;
    tbl[0] = '{len: 4'd3,  ab: -1, writes: 3, done_c: 7};
    tbl[1] = '{len: 4'd0,  ab: -1, writes: 0, done_c: 1};
    tbl[2] = '{len: 4'd8,  ab: 5,  writes: 3, done_c: 7};
    tbl[3] = '{len: 4'd12, ab: -1, writes: 8, done_c: 17};
    tbl[4] = '{len: 4'd1,  ab: -1, writes: 1, done_c: 3};
    tbl[5] = '{len: 4'd8,  ab: 6,  writes: 3, done_c: 7};
    tbl[6] = '{len: 4'd8,  ab: 1,  writes: 1, done_c: 3};

    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.start = 1'b0; bus.len = '0; bus.abort = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 0, 32'(sample()), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) load(3'(i), base[i]);

    // Directed table: write count and done cycle, plus full trace via the model
    for (int i = 0; i < 7; i++) begin
      run_seq(tbl[i].len, tbl[i].ab, -1, w, d);
      chk("tbl_writes", i, 32'(w), 32'(tbl[i].writes));
      chk("tbl_done_cycle", i, 32'(d), 32'(tbl[i].done_c));
    end

    // prog_we and start while busy are both ignored
    run_seq(4'd3, -1, 3, w, d);
    chk("inject_writes", 0, 32'(w), 32'd3);
    chk("inject_done", 0, 32'(d), 32'd7);
    run_seq(4'd1, -1, -1, w, d);
    chk("inject_readback_writes", 0, 32'(w), 32'd1);

    // HALT at slot 1 stops after one write with pc left at 1
    load(3'd1, 16'hF000);
    run_seq(4'd5, -1, -1, w, d);
    chk("halt1_writes", 0, 32'(w), 32'd1);
    chk("halt1_done", 0, 32'(d), 32'd5);
    chk("halt1_pc", 0, 32'(bus.pc), 32'd1);
    load(3'd0, 16'hF000);
    run_seq(4'd4, -1, -1, w, d);
    chk("halt0_writes", 0, 32'(w), 32'd0);
    chk("halt0_done", 0, 32'(d), 32'd3);
    load(3'd0, base[0]);
    load(3'd1, base[1]);

    // Reset during the WRITE of op 1 kills the write and returns to idle
    bus.len = 4'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.len = '0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_pre_we", 4, 32'({bus.reg_we, bus.rd_addr}), 32'({1'b1, 4'h4}));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_outputs", 5, 32'(sample()), 32'h0);
    rst = 1'b0;
    m_pc = 3'd0;
    run_seq(4'd3, -1, -1, w, d);
    chk("rst_rerun_writes", 0, 32'(w), 32'd3);

    // Random programs, lengths and aborts against the model
    for (int it = 0; it < 30; it++) begin
      for (int s = 0; s < 8; s++) begin
        word = 16'($urandom);
        if ($urandom_range(0, 5) == 0) word[15:12] = 4'hF;
        else if (word[15:12] == 4'hF) word[15:12] = 4'hE;
        load(3'(s), word);
      end
      rl = 4'($urandom_range(0, 15));
      rab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 18)) : -1;
      run_seq(rl, rab, -1, w, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
